// File: rtl/leitor_matriz_vagas_pkg.sv
// Shared definitions for the parking-lot sensor matrix blocks
// (scanner, display and counter).
package pkg_vagas;

  localparam int NUM_COLS  = 2;
  localparam int NUM_ROWS  = 4;
  localparam int NUM_VAGAS = NUM_COLS * NUM_ROWS;

  typedef enum logic [1:0] {
    COL0,
    COL1,
    UPD
  } estado_t;

endpackage

// File: rtl/leitor_matriz_vagas_if.sv
// Sensor-matrix scanner bus: row sense in; column drive, occupancy and
// event pulses out.
interface leitor_matriz_vagas_if;
  import pkg_vagas::*;

  logic [NUM_ROWS-1:0]  Linhas;
  logic [NUM_COLS-1:0]  Colunas;
  logic [NUM_VAGAS-1:0] Vagas;
  logic                 Mudou;
  logic                 Quadro;

  modport master (
    input  Linhas,
    output Colunas,
    output Vagas,
    output Mudou,
    output Quadro
  );

  modport slave (
    output Linhas,
    input  Colunas,
    input  Vagas,
    input  Mudou,
    input  Quadro
  );

endinterface

// File: rtl/leitor_matriz_vagas_sincronizador.sv
// Parameterized-width two-flop synchronizer for asynchronous level inputs.
module sincronizador #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sinc_p0;
  logic [WIDTH-1:0] sinc_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sinc_p0 <= '0;
      sinc_p1 <= '0;
    end else begin
      sinc_p0 <= d;
      sinc_p1 <= sinc_p0;
    end
  end

  assign q = sinc_p1;

endmodule

// File: rtl/leitor_matriz_vagas.sv
// Column-scanning reader for the parking sensor matrix: assembles an
// 8-bit occupancy frame per scan and debounces it into Vagas.
module leitor_matriz_vagas
  import pkg_vagas::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  leitor_matriz_vagas_if.master bus
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int EST_W = $clog2(DEBOUNCE + 1);

  estado_t              estado, estado_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 fim_dwell;
  logic [NUM_COLS-1:0]  colunas;
  logic [NUM_ROWS-1:0]  linhas_sinc;
  logic [NUM_VAGAS-1:0] raw;
  logic [NUM_VAGAS-1:0] ultimo;
  logic [NUM_VAGAS-1:0] vagas;
  logic [EST_W-1:0]     estavel, estavel_nxt;
  logic                 aceita;
  logic                 mudou;
  logic                 quadro;

  function automatic logic [EST_W-1:0] sat_inc(input logic [EST_W-1:0] v);
    if (v >= EST_W'(DEBOUNCE)) return EST_W'(DEBOUNCE);
    return v + EST_W'(1);
  endfunction

  sincronizador #(
    .WIDTH(NUM_ROWS)
  ) u_sincronizador (
    .clk (Clock),
    .rst (Reset),
    .d   (bus.Linhas),
    .q   (linhas_sinc)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado <= COL0;
      cnt    <= '0;
    end else begin
      estado <= estado_nxt;
      cnt    <= cnt_nxt;
    end
  end

  assign fim_dwell = (cnt == CNT_W'(SCAN_DIV - 1));

  always_comb begin
    estado_nxt = estado;
    cnt_nxt    = cnt + CNT_W'(1);
    colunas    = '0;
    case (estado)
      COL0: begin
        colunas = 2'b01;
        if (fim_dwell) begin
          estado_nxt = COL1;
          cnt_nxt    = '0;
        end
      end
      COL1: begin
        colunas = 2'b10;
        if (fim_dwell) begin
          estado_nxt = UPD;
          cnt_nxt    = '0;
        end
      end
      UPD: begin
        estado_nxt = COL0;
        cnt_nxt    = '0;
      end
      default: begin
        estado_nxt = COL0;
        cnt_nxt    = '0;
      end
    endcase
    // No column is driven while held in reset, even though the FSM sits in COL0.
    if (Reset) colunas = '0;
  end

  // Frame assembly: sample rows on the last dwell cycle of each column.
  always_ff @(posedge Clock) begin
    if (estado == COL0 && fim_dwell) raw[NUM_ROWS-1:0]         <= linhas_sinc;
    if (estado == COL1 && fim_dwell) raw[NUM_VAGAS-1:NUM_ROWS] <= linhas_sinc;
  end

  always_comb begin
    estavel_nxt = (raw == ultimo) ? sat_inc(estavel) : EST_W'(1);
    aceita      = (estavel_nxt == EST_W'(DEBOUNCE)) && (raw != vagas);
  end

  // Debounce update, once per frame in UPD.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      vagas   <= '0;
      ultimo  <= '0;
      estavel <= '0;
      mudou   <= 1'b0;
      quadro  <= 1'b0;
    end else begin
      mudou  <= 1'b0;
      quadro <= 1'b0;
      if (estado == UPD) begin
        ultimo  <= raw;
        estavel <= estavel_nxt;
        quadro  <= 1'b1;
        if (aceita) begin
          vagas <= raw;
          mudou <= 1'b1;
        end
      end
    end
  end

  assign bus.Colunas = colunas;
  assign bus.Vagas   = vagas;
  assign bus.Mudou   = mudou;
  assign bus.Quadro  = quadro;

endmodule

// File: tb/tb_leitor_matriz_vagas.sv
// Directed bench for leitor_matriz_vagas with SCAN_DIV=4, DEBOUNCE=3 (9-cycle frame).
module tb_leitor_matriz_vagas;
  import pkg_vagas::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ocup;
  logic       forca;
  logic [3:0] forca_val;
  int         total;
  int         bad;

  always #5 clk = ~clk;

  leitor_matriz_vagas_if intf ();

  // Sensor matrix model: the driven column exposes its four sensors on the rows.
  assign intf.Linhas = forca ? forca_val :
                       (intf.Colunas == 2'b01) ? ocup[3:0] :
                       (intf.Colunas == 2'b10) ? ocup[7:4] : 4'h0;

  leitor_matriz_vagas #(
    .SCAN_DIV (4),
    .DEBOUNCE (3)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (intf)
  );

  function automatic logic [1:0] col_esperada(input int k);
    int p;
    p = k % 9;
    if (p < 4) return 2'b01;
    if (p < 8) return 2'b10;
    return 2'b00;
  endfunction

  task automatic alinhar();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!intf.Quadro && n < 20);
    if (!intf.Quadro) begin
      total++;
      bad++;
      $display("FAIL align_quadro: no Quadro pulse within %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    forca = 1'b1;
    forca_val = 4'hF;
    ocup = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (intf.Vagas !== 8'h00) begin bad++; $display("FAIL reset_vagas: got %h want 00", intf.Vagas); end
      total++;
      if (intf.Colunas !== 2'b00) begin bad++; $display("FAIL reset_colunas: got %b want 00", intf.Colunas); end
      total++;
      if (intf.Mudou !== 1'b0 || intf.Quadro !== 1'b0) begin
        bad++; $display("FAIL reset_pulses: mudou=%b quadro=%b want 0 0", intf.Mudou, intf.Quadro);
      end
    end
    rst = 1'b0;
    forca = 1'b0;
    for (int k = 0; k < 18; k++) begin
      if (k == 0) #1; else @(negedge clk);
      total++;
      if (intf.Colunas !== col_esperada(k)) begin
        bad++; $display("FAIL reset_seq_colunas k=%0d: got %b want %b", k, intf.Colunas, col_esperada(k));
      end
      total++;
      if (intf.Quadro !== (k == 9)) begin
        bad++; $display("FAIL reset_seq_quadro k=%0d: got %b want %b", k, intf.Quadro, (k == 9));
      end
    end
  endtask

  task automatic test_glitch();
    alinhar();
    ocup = 8'hFF;
    for (int f = 1; f <= 5; f++) begin
      if (f >= 3) ocup = 8'h00;
      for (int c = 1; c <= 9; c++) begin
        @(negedge clk);
        total++;
        if (intf.Quadro !== (c == 9)) begin
          bad++; $display("FAIL glitch_quadro f=%0d c=%0d: got %b want %b", f, c, intf.Quadro, (c == 9));
        end
        total++;
        if (intf.Mudou !== 1'b0) begin bad++; $display("FAIL glitch_mudou f=%0d c=%0d: got 1 want 0", f, c); end
        total++;
        if (intf.Vagas !== 8'h00) begin bad++; $display("FAIL glitch_vagas f=%0d c=%0d: got %h want 00", f, c, intf.Vagas); end
      end
    end
  endtask

  task automatic test_aceitacao();
    logic       exp_m;
    logic [7:0] exp_v;
    alinhar();
    ocup = 8'h40;
    for (int f = 1; f <= 5; f++) begin
      for (int c = 1; c <= 9; c++) begin
        @(negedge clk);
        exp_m = (f == 3 && c == 9);
        exp_v = (f > 3 || (f == 3 && c == 9)) ? 8'h40 : 8'h00;
        total++;
        if (intf.Mudou !== exp_m) begin
          bad++; $display("FAIL accept_mudou f=%0d c=%0d: got %b want %b", f, c, intf.Mudou, exp_m);
        end
        total++;
        if (intf.Vagas !== exp_v) begin
          bad++; $display("FAIL accept_vagas f=%0d c=%0d: got %h want %h", f, c, intf.Vagas, exp_v);
        end
        total++;
        if (intf.Quadro !== (c == 9)) begin
          bad++; $display("FAIL accept_quadro f=%0d c=%0d: got %b want %b", f, c, intf.Quadro, (c == 9));
        end
      end
    end
  endtask

  task automatic test_alternado();
    alinhar();
    for (int f = 1; f <= 6; f++) begin
      ocup = (f % 2 == 1) ? 8'h0F : 8'hF0;
      for (int c = 1; c <= 9; c++) begin
        @(negedge clk);
        total++;
        if (intf.Mudou !== 1'b0) begin bad++; $display("FAIL alt_mudou f=%0d c=%0d: got 1 want 0", f, c); end
        total++;
        if (intf.Vagas !== 8'h40) begin bad++; $display("FAIL alt_vagas f=%0d c=%0d: got %h want 40", f, c, intf.Vagas); end
        if (c == 9) begin
          total++;
          if (dut.estavel > 1) begin bad++; $display("FAIL alt_estavel f=%0d: got %0d want <=1", f, dut.estavel); end
        end
      end
    end
  endtask

  task automatic test_reset_meio();
    logic [7:0] exp_v;
    ocup = 8'h40;
    alinhar();
    total++;
    if (intf.Vagas !== 8'h40) begin bad++; $display("FAIL midrst_pre_vagas: got %h want 40", intf.Vagas); end
    repeat (5) @(negedge clk);
    total++;
    if (intf.Colunas !== 2'b10) begin bad++; $display("FAIL midrst_in_col1: got %b want 10", intf.Colunas); end
    rst = 1'b1;
    forca = 1'b1;
    forca_val = 4'hF;
    @(negedge clk);
    total++;
    if (intf.Vagas !== 8'h00) begin bad++; $display("FAIL midrst_vagas: got %h want 00", intf.Vagas); end
    total++;
    if (intf.Mudou !== 1'b0 || intf.Quadro !== 1'b0) begin
      bad++; $display("FAIL midrst_pulses: mudou=%b quadro=%b want 0 0", intf.Mudou, intf.Quadro);
    end
    total++;
    if (dut.estado !== COL0) begin bad++; $display("FAIL midrst_estado: got %0d want %0d", dut.estado, COL0); end
    rst = 1'b0;
    for (int k = 0; k <= 27; k++) begin
      if (k == 0) #1; else @(negedge clk);
      exp_v = (k >= 27) ? 8'hFF : 8'h00;
      total++;
      if (intf.Colunas !== col_esperada(k)) begin
        bad++; $display("FAIL midrst_colunas k=%0d: got %b want %b", k, intf.Colunas, col_esperada(k));
      end
      total++;
      if (intf.Vagas !== exp_v) begin bad++; $display("FAIL midrst_refill k=%0d: got %h want %h", k, intf.Vagas, exp_v); end
      total++;
      if (intf.Mudou !== (k == 27)) begin
        bad++; $display("FAIL midrst_mudou k=%0d: got %b want %b", k, intf.Mudou, (k == 27));
      end
    end
    forca = 1'b0;
  endtask

  task automatic test_cheio_vazio();
    int         npulsos;
    int         k1, k2;
    logic [7:0] v1, v2;
    npulsos = 0;
    k1 = -1; k2 = -1;
    v1 = 8'hxx; v2 = 8'hxx;
    rst = 1'b1;
    ocup = 8'hFF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k <= 81; k++) begin
      if (k == 0) #1; else @(negedge clk);
      if (k == 45) ocup = 8'h00;
      total++;
      if (intf.Mudou && !intf.Quadro) begin bad++; $display("FAIL swing_mudou_sem_quadro k=%0d: mudou=1 quadro=0", k); end
      if (intf.Mudou) begin
        npulsos++;
        if (npulsos == 1) begin v1 = intf.Vagas; k1 = k; end
        if (npulsos == 2) begin v2 = intf.Vagas; k2 = k; end
      end
    end
    total++;
    if (npulsos != 2) begin bad++; $display("FAIL swing_count: got %0d want 2", npulsos); end
    total++;
    if (v1 !== 8'hFF || k1 != 27) begin bad++; $display("FAIL swing_first: got %h at %0d want ff at 27", v1, k1); end
    total++;
    if (v2 !== 8'h00 || k2 != 72) begin bad++; $display("FAIL swing_second: got %h at %0d want 00 at 72", v2, k2); end
    total++;
    if (intf.Vagas !== 8'h00) begin bad++; $display("FAIL swing_final: got %h want 00", intf.Vagas); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    forca = 1'b0;
    forca_val = 4'h0;
    ocup = 8'h00;
    test_reset();
    test_glitch();
    test_aceitacao();
    test_alternado();
    test_reset_meio();
    test_cheio_vazio();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
